// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative MUL execution unit.
package mul_pkg;

    localparam int DATA_W    = 16;
    localparam int PREG_W    = 5;
    localparam int CNT_W     = 5;
    localparam int MUL_ITERS = DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier: one op in flight, single-cycle broadcast on completion.
// Optional MUL_EARLY_OUT_EN ends the iteration as soon as the remaining multiplier is zero.
module mul_iter_unit
    import mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    // Issue handshake: an op is taken on a rising edge where issue_valid && issue_ready && !flush.
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [PREG_W-1:0] Pw_issue,
    input  logic [DATA_W-1:0] busA_mul,
    input  logic [DATA_W-1:0] busB_mul,
    input  logic              flush,
    output logic              busy,
    output logic [PREG_W-1:0] Pw_Result_mul,
    output logic [DATA_W-1:0] Result_mul,
    output logic              valid_Result_mul
);

    mul_state_t        state;
    mul_state_t        state_next;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic [PREG_W-1:0] tag;
    logic [DATA_W-1:0] res_q;
    logic [PREG_W-1:0] pw_q;

    logic              accept;
    logic              last_iter;
    logic [DATA_W-1:0] acc_step;
    logic [DATA_W-1:0] mplier_sh;

    always_comb begin
        accept    = 1'b0;
        last_iter = 1'b0;
        acc_step  = acc;
        mplier_sh = mplier >> 1;

        accept = issue_valid && issue_ready && !flush;
        if (mplier[0]) begin
            acc_step = acc + mcand;
        end

        last_iter = (cnt == CNT_W'(MUL_ITERS - 1));
`ifdef MUL_EARLY_OUT_EN
        // Nothing left to add once the shifted multiplier is empty.
        if (mplier_sh == '0) begin
            last_iter = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last_iter) state_next = DONE;
            DONE: state_next = accept ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            tag    <= '0;
        end else if (accept) begin
            mcand  <= busA_mul;
            mplier <= busB_mul;
            acc    <= '0;
            cnt    <= '0;
            tag    <= Pw_issue;
        end else if (state == BUSY && !flush) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier_sh;
            cnt    <= cnt + 1'b1;
        end
    end

    // Broadcast data is captured on entry to DONE and held until the next completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
            pw_q  <= '0;
        end else if (state == BUSY && last_iter && !flush) begin
            res_q <= acc_step;
            pw_q  <= tag;
        end
    end

    assign issue_ready      = (state == IDLE) || (state == DONE);
    assign busy             = (state == BUSY);
    assign valid_Result_mul = (state == DONE) && !flush;
    assign Result_mul       = res_q;
    assign Pw_Result_mul    = pw_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed bench for mul_iter_unit: scoreboard of {cycle, tag, data} checked on every broadcast.
module tb_mul_iter_unit;
    import mul_pkg::*;

    localparam int EW = 32 + PREG_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic [PREG_W-1:0] Pw_issue = '0;
    logic [DATA_W-1:0] busA_mul = '0;
    logic [DATA_W-1:0] busB_mul = '0;
    logic              flush = 1'b0;
    logic              busy;
    logic [PREG_W-1:0] Pw_Result_mul;
    logic [DATA_W-1:0] Result_mul;
    logic              valid_Result_mul;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] cyc = '0;
    logic [EW-1:0] exp_q[$];

    mul_iter_unit dut (
        .clk              (clk),
        .rst              (rst),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .Pw_issue         (Pw_issue),
        .busA_mul         (busA_mul),
        .busB_mul         (busB_mul),
        .flush            (flush),
        .busy             (busy),
        .Pw_Result_mul    (Pw_Result_mul),
        .Result_mul       (Result_mul),
        .valid_Result_mul (valid_Result_mul)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [DATA_W-1:0] b);
        int l;
        l = 17;
`ifdef MUL_EARLY_OUT_EN
        l = 2;
        for (int i = 0; i < DATA_W; i++) begin
            if (b[i]) l = 2 + i;
        end
`endif
        return l;
    endfunction

    // Issue one op; returns #1 after the accept edge (cycle 1 of the op).
    task automatic issue(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [PREG_W-1:0] pw, input bit expect_result);
        logic [31:0] prod;
        int waited;
        waited = 0;
        @(negedge clk);
        issue_valid = 1'b1;
        busA_mul    = a;
        busB_mul    = b;
        Pw_issue    = pw;
        while (!issue_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            check("issue_ready_timeout", 64'(waited), 64'd0);
        end
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        prod = 32'(a) * 32'(b);
        if (expect_result) begin
            exp_q.push_back({cyc - 1 + 32'(lat_of(b)), pw, prod[DATA_W-1:0]});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst && valid_Result_mul) begin
            if (exp_q.size() == 0) begin
                check("unexpected_broadcast", 64'(Result_mul), 64'hDEAD);
            end else begin
                e = exp_q.pop_front();
                check("bcast_cycle", 64'(cyc), 64'(e[EW-1 -: 32]));
                check("bcast_tag", 64'(Pw_Result_mul), 64'(e[DATA_W +: PREG_W]));
                check("bcast_data", 64'(Result_mul), 64'(e[DATA_W-1:0]));
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] ra, rb;
        // reset
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(issue_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid_Result_mul), 64'd0);
        check("rst_pw", 64'(Pw_Result_mul), 64'd0);
        check("rst_result", 64'(Result_mul), 64'd0);
        rst = 1'b0;

        // single op, ready low through cycles 1..16
        issue(16'h0003, 16'h0005, 5'd7, 1'b1);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("busy_ready_low", 64'(issue_ready), 64'd0);
        end
        drain();

        // wrap and shifted operand
        issue(16'hFFFF, 16'hFFFF, 5'd3, 1'b1);
        drain();
        issue(16'h1234, 16'h0100, 5'd0, 1'b1);
        drain();

        // back-to-back: op2 accepted in op1's DONE cycle
        issue(16'h0002, 16'h0003, 5'd1, 1'b1);
        issue(16'h0004, 16'h0005, 5'd2, 1'b1);
        drain();

        // flush in cycle 10
        issue(16'h00AA, 16'h0055, 5'd9, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_ready", 64'(issue_ready), 64'd1);
        check("flush_busy_idle", 64'(busy), 64'd0);
        repeat (20) @(posedge clk);

        // flush in the DONE cycle
        issue(16'h0011, 16'h0022, 5'd10, 1'b0);
        repeat (16) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_done_valid", 64'(valid_Result_mul), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_done_ready", 64'(issue_ready), 64'd1);
        issue(16'h0007, 16'h0006, 5'd11, 1'b1);
        drain();

        // reset mid-BUSY
        issue(16'h0123, 16'h0456, 5'd12, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", 64'(valid_Result_mul), 64'd0);
        check("midrst_pw", 64'(Pw_Result_mul), 64'd0);
        check("midrst_result", 64'(Result_mul), 64'd0);
        check("midrst_ready", 64'(issue_ready), 64'd1);
        check("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(posedge clk);

        // early-out vectors (latency depends on the build)
        issue(16'h0009, 16'h0000, 5'd4, 1'b1);
        drain();
        issue(16'h0009, 16'h0004, 5'd5, 1'b1);
        drain();

        // random operands
        for (int i = 0; i < 6; i++) begin
            ra = DATA_W'($urandom_range(0, 16'hFFFF));
            rb = DATA_W'($urandom_range(0, 16'hFFFF));
            issue(ra, rb, PREG_W'($urandom_range(0, 31)), 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
